// File: rtl/display_clock_reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_clock_reconfig_pkg
// Description : Shared types and constants for the MMCM display-mode switcher:
//               FSM state encoding, table-entry field slices, DRP widths.
// Revision    : 1.0 - initial release
// ============================================================================
package display_clock_reconfig_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;
    localparam int TBL_W  = 39;

    // Table entry layout: {drp_addr, keep_mask, set_bits}
    localparam int TBL_ADDR_MSB = 38;
    localparam int TBL_ADDR_LSB = 32;
    localparam int TBL_MASK_MSB = 31;
    localparam int TBL_MASK_LSB = 16;
    localparam int TBL_SET_MSB  = 15;
    localparam int TBL_SET_LSB  = 0;

    typedef enum logic [3:0] {
        S_BOOT_HOLD   = 4'd0,
        S_LOCK_WAIT   = 4'd1,
        S_IDLE        = 4'd2,
        S_RST_ASSERT  = 4'd3,
        S_FETCH       = 4'd4,
        S_RD_REQ      = 4'd5,
        S_RD_WAIT     = 4'd6,
        S_WR_REQ      = 4'd7,
        S_WR_WAIT     = 4'd8,
        S_RST_RELEASE = 4'd9
    } state_t;

    // Read-modify-write merge of a DRP register with a table entry
    function automatic logic [DRP_DW-1:0] drp_merge(
        input logic [DRP_DW-1:0] rd_val,
        input logic [DRP_DW-1:0] keep_mask,
        input logic [DRP_DW-1:0] set_bits
    );
        return (rd_val & keep_mask) | set_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_clock_reconfig_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : display_clock_reconfig_sync_2ff
// Description : Single-bit two-flop synchroniser (used for MMCM LOCKED).
// Revision    : 1.0 - initial release
// ============================================================================
module display_clock_reconfig_sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state of the two-stage shift chain
    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // Synchroniser flops, cleared while in reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/display_clock_reconfig.sv
`default_nettype none
// ============================================================================
// Module      : display_clock_reconfig
// Description : Runtime display-mode switcher for a 7-series MMCM. Applies a
//               per-mode table of DRP read-modify-write updates with the MMCM
//               held in reset, then re-locks and supervises LOCKED.
// Revision    : 1.0 - initial release
// ============================================================================
module display_clock_reconfig
    import display_clock_reconfig_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int REGS_PER_MODE = 8,
    parameter int INIT_MODE     = 0,
    parameter int RST_HOLD      = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int DRDY_TIMEOUT  = 64,
    parameter int MAX_RETRY     = 3,
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int TW = ((NUM_MODES * REGS_PER_MODE) > 1) ? $clog2(NUM_MODES * REGS_PER_MODE) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mode_req,
    input  logic [MW-1:0]     i_mode,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [MW-1:0]     o_cur_mode,
    output logic [TW-1:0]     o_tbl_addr,
    input  logic [TBL_W-1:0]  i_tbl_data,
    output logic [DRP_AW-1:0] o_daddr,
    output logic              o_den,
    output logic              o_dwe,
    output logic [DRP_DW-1:0] o_di,
    input  logic [DRP_DW-1:0] i_do,
    input  logic              i_drdy,
    input  logic              i_mmcm_locked,
    output logic              o_mmcm_rst,
    output logic [7:0]        o_lock_lost
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > RST_HOLD)
                           ? ((LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT)
                           : ((RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int NW = (REGS_PER_MODE > 1) ? $clog2(REGS_PER_MODE) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NW-1:0]     n_q, n_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [MW-1:0]     mode_q, mode_d;
    logic              from_req_q, from_req_d;
    logic [DRP_DW-1:0] mask_q, mask_d;
    logic [DRP_DW-1:0] set_q, set_d;
    logic              lock_prev_q, lock_prev_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [MW-1:0]     cur_mode_q, cur_mode_d;
    logic [TW-1:0]     tbl_addr_q, tbl_addr_d;
    logic [DRP_AW-1:0] daddr_q, daddr_d;
    logic              den_q, den_d;
    logic              dwe_q, dwe_d;
    logic [DRP_DW-1:0] di_q, di_d;
    logic              mmcm_rst_q, mmcm_rst_d;
    logic [7:0]        lock_lost_q, lock_lost_d;

    logic w_locked;
    logic w_mode_ok;

    display_clock_reconfig_sync_2ff u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_mmcm_locked),
        .o_q   (w_locked)
    );

    // Range check only exists when the mode field can encode unused values
    generate
        if ((2 ** MW) > NUM_MODES) begin : g_mode_range_chk
            assign w_mode_ok = (int'(i_mode) < NUM_MODES);
        end else begin : g_mode_always_ok
            assign w_mode_ok = 1'b1;
        end
    endgenerate

    function automatic logic [TW-1:0] entry_addr(input logic [MW-1:0] m, input logic [NW-1:0] n);
        return TW'(m) * TW'(REGS_PER_MODE) + TW'(n);
    endfunction

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        retry_d     = retry_q;
        mode_d      = mode_q;
        from_req_d  = from_req_q;
        mask_d      = mask_q;
        set_d       = set_q;
        lock_prev_d = w_locked;
        done_d      = 1'b0;
        err_d       = err_q;
        cur_mode_d  = cur_mode_q;
        tbl_addr_d  = tbl_addr_q;
        daddr_d     = daddr_q;
        den_d       = 1'b0;
        dwe_d       = 1'b0;
        di_d        = di_q;
        mmcm_rst_d  = mmcm_rst_q;
        lock_lost_d = lock_lost_q;

        if ((state_q == S_IDLE) && lock_prev_q && !w_locked && (lock_lost_q != 8'hFF)) begin
            lock_lost_d = lock_lost_q + 8'd1;
        end

        case (state_q)
            // Boot hold and lock-retry pulse share this state; no DRP traffic
            S_BOOT_HOLD: begin
                mmcm_rst_d = 1'b1;
                if (cnt_q == CW'(RST_HOLD - 1)) begin
                    cnt_d      = '0;
                    mmcm_rst_d = 1'b0;
                    state_d    = S_LOCK_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOCK_WAIT: begin
                if (w_locked) begin
                    if (from_req_q) begin
                        cur_mode_d = mode_q;
                        done_d     = 1'b1;
                    end
                    from_req_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    cnt_d = '0;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d    = retry_q + RW'(1);
                        mmcm_rst_d = 1'b1;
                        state_d    = S_BOOT_HOLD;
                    end else begin
                        err_d      = 1'b1;
                        from_req_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (i_mode_req) begin
                    if (w_mode_ok) begin
                        mode_d     = i_mode;
                        n_d        = '0;
                        err_d      = 1'b0;
                        from_req_d = 1'b1;
                        retry_d    = '0;
                        cnt_d      = '0;
                        mmcm_rst_d = 1'b1;
                        state_d    = S_RST_ASSERT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RST_ASSERT: begin
                if (cnt_q == CW'(RST_HOLD - 1)) begin
                    cnt_d      = '0;
                    tbl_addr_d = entry_addr(mode_q, n_q);
                    state_d    = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // Two cycles: present the address, then capture the ROM output
            S_FETCH: begin
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else begin
                    cnt_d   = '0;
                    mask_d  = i_tbl_data[TBL_MASK_MSB:TBL_MASK_LSB];
                    set_d   = i_tbl_data[TBL_SET_MSB:TBL_SET_LSB];
                    daddr_d = i_tbl_data[TBL_ADDR_MSB:TBL_ADDR_LSB];
                    den_d   = 1'b1;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (i_drdy) begin
                    cnt_d = '0;
                    if (state_q == S_RD_WAIT) begin
                        di_d    = drp_merge(i_do, mask_q, set_q);
                        den_d   = 1'b1;
                        dwe_d   = 1'b1;
                        state_d = S_WR_REQ;
                    end else if (n_q == NW'(REGS_PER_MODE - 1)) begin
                        state_d = S_RST_RELEASE;
                    end else begin
                        n_d        = n_q + NW'(1);
                        tbl_addr_d = entry_addr(mode_q, n_q + NW'(1));
                        state_d    = S_FETCH;
                    end
                end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
                    // DRP stalled: give up, let the old settings re-lock
                    cnt_d      = '0;
                    err_d      = 1'b1;
                    from_req_d = 1'b0;
                    mmcm_rst_d = 1'b0;
                    state_d    = S_LOCK_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_REQ: begin
                state_d = S_WR_WAIT;
            end
            S_RST_RELEASE: begin
                cnt_d      = '0;
                mmcm_rst_d = 1'b0;
                state_d    = S_LOCK_WAIT;
            end
            default: begin
                state_d = S_BOOT_HOLD;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset abandons any sequence in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_BOOT_HOLD;
            cnt_q       <= '0;
            n_q         <= '0;
            retry_q     <= '0;
            mode_q      <= MW'(INIT_MODE);
            from_req_q  <= 1'b0;
            mask_q      <= '0;
            set_q       <= '0;
            lock_prev_q <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_mode_q  <= MW'(INIT_MODE);
            tbl_addr_q  <= '0;
            daddr_q     <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            di_q        <= '0;
            mmcm_rst_q  <= 1'b1;
            lock_lost_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            retry_q     <= retry_d;
            mode_q      <= mode_d;
            from_req_q  <= from_req_d;
            mask_q      <= mask_d;
            set_q       <= set_d;
            lock_prev_q <= lock_prev_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cur_mode_q  <= cur_mode_d;
            tbl_addr_q  <= tbl_addr_d;
            daddr_q     <= daddr_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            di_q        <= di_d;
            mmcm_rst_q  <= mmcm_rst_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_busy      = ~ready_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_cur_mode  = cur_mode_q;
    assign o_tbl_addr  = tbl_addr_q;
    assign o_daddr     = daddr_q;
    assign o_den       = den_q;
    assign o_dwe       = dwe_q;
    assign o_di        = di_q;
    assign o_mmcm_rst  = mmcm_rst_q;
    assign o_lock_lost = lock_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_display_clock_reconfig.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_clock_reconfig
// Description : Self-checking bench for display_clock_reconfig with table ROM,
//               DRP and MMCM lock models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_clock_reconfig;

    localparam int NUM_MODES = 3;
    localparam int REGS      = 8;
    localparam int RST_HOLD  = 16;
    localparam int LOCK_TO   = 512;
    localparam int DRDY_TO   = 64;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_mode_req = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic        o_ready, o_busy, o_done, o_err;
    logic [1:0]  o_cur_mode;
    logic [4:0]  o_tbl_addr;
    logic [38:0] i_tbl_data = '0;
    logic [6:0]  o_daddr;
    logic        o_den, o_dwe;
    logic [15:0] o_di;
    logic [15:0] i_do = 16'hFFFF;
    logic        i_drdy = 1'b0;
    logic        i_mmcm_locked = 1'b0;
    logic        o_mmcm_rst;
    logic [7:0]  o_lock_lost;

    always #5 clk = ~clk;

    display_clock_reconfig #(
        .NUM_MODES     (NUM_MODES),
        .REGS_PER_MODE (REGS),
        .INIT_MODE     (0),
        .RST_HOLD      (RST_HOLD),
        .LOCK_TIMEOUT  (LOCK_TO),
        .DRDY_TIMEOUT  (DRDY_TO),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_mode_req    (i_mode_req),
        .i_mode        (i_mode),
        .o_ready       (o_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_cur_mode    (o_cur_mode),
        .o_tbl_addr    (o_tbl_addr),
        .i_tbl_data    (i_tbl_data),
        .o_daddr       (o_daddr),
        .o_den         (o_den),
        .o_dwe         (o_dwe),
        .o_di          (o_di),
        .i_do          (i_do),
        .i_drdy        (i_drdy),
        .i_mmcm_locked (i_mmcm_locked),
        .o_mmcm_rst    (o_mmcm_rst),
        .o_lock_lost   (o_lock_lost)
    );

    // ---------------- table ROM (one-cycle read latency) ----------------
    function automatic logic [38:0] rom_fn(input logic [4:0] a);
        logic [15:0] m;
        logic [15:0] s;
        case (a[4:3])
            2'd0:    begin m = 16'h0000; s = 16'hA5A5; end
            2'd1:    begin m = 16'hF0F0; s = 16'h0305; end
            2'd2:    begin m = 16'h00FF; s = 16'h1200; end
            default: begin m = 16'h0000; s = 16'h0000; end
        endcase
        return {2'b00, a, m, s};
    endfunction

    always @(posedge clk) i_tbl_data <= rom_fn(o_tbl_addr);

    // ---------------- DRP model and traffic monitor ----------------
    int dcnt = 0;
    int den_total = 0;
    int done_total = 0;
    int rst_rises = 0;
    int b2b_viol = 0;
    int rst_viol = 0;
    logic den_prev = 1'b0;
    logic rst_prev = 1'b1;
    logic [6:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    always @(negedge clk) begin
        i_drdy = 1'b0;
        if (i_rst) begin
            dcnt = 0;
        end else begin
            if (dcnt > 0) begin
                dcnt = dcnt - 1;
                if (dcnt == 0) i_drdy = 1'b1;
            end
            if (o_den) begin
                dcnt = 5;
                den_total++;
            end
            if (o_den && den_prev) b2b_viol++;
            if (o_den && o_dwe) begin
                wr_addr_q.push_back(o_daddr);
                wr_data_q.push_back(o_di);
                if (!o_mmcm_rst) rst_viol++;
            end
            if (o_done) done_total++;
            if (o_mmcm_rst && !rst_prev) rst_rises++;
        end
        den_prev = o_den;
        rst_prev = o_mmcm_rst;
    end

    // ---------------- MMCM lock model ----------------
    logic lock_en = 1'b1;
    logic drop_req = 1'b0;
    int   lcnt = 0;

    always @(negedge clk) begin
        if (i_rst || o_mmcm_rst || drop_req) begin
            i_mmcm_locked = 1'b0;
            lcnt = 0;
        end else if (lock_en && !i_mmcm_locked) begin
            lcnt++;
            if (lcnt >= 200) i_mmcm_locked = 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int max_cyc, input string name);
        int k = 0;
        while (!o_ready && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(o_ready), 32'd1);
    endtask

    task automatic req(input logic [1:0] m);
        i_mode     = m;
        i_mode_req = 1'b1;
        @(negedge clk);
        i_mode_req = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        bit          poke;
        bit          exp_err;
        logic [1:0]  exp_cur;
        int          exp_done;
        int          exp_nwr;
        logic [6:0]  exp_base;
        logic [15:0] exp_data;
    } vec_t;

    task automatic do_vec(input vec_t v, input string tag);
        int w0;
        int d0;
        w0 = wr_addr_q.size();
        d0 = done_total;
        req(v.mode);
        if (v.poke) begin
            repeat (20) @(negedge clk);
            chk({tag, "_busy"}, 32'(o_busy), 32'd1);
            req(2'd0);
        end
        wait_ready(2000, {tag, "_ready"});
        repeat (2) @(negedge clk);
        chk({tag, "_err"}, 32'(o_err), 32'(v.exp_err));
        chk({tag, "_cur_mode"}, 32'(o_cur_mode), 32'(v.exp_cur));
        chk({tag, "_done"}, 32'(done_total - d0), 32'(v.exp_done));
        chk({tag, "_nwr"}, 32'(wr_addr_q.size() - w0), 32'(v.exp_nwr));
        for (int i = 0; i < v.exp_nwr && (w0 + i) < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr_q[w0 + i]), 32'(v.exp_base + 7'(i)));
            chk($sformatf("%s_wr%0d_data", tag, i), 32'(wr_data_q[w0 + i]), 32'(v.exp_data));
        end
    endtask

    vec_t vecs[4];

    initial begin
        int r0;
        int d0;
        int k;

        //               mode  poke err cur done nwr base    data
        vecs[0] = '{2'd2, 1'b0, 1'b0, 2'd2, 1, 8, 7'd16, 16'h12FF};
        vecs[1] = '{2'd3, 1'b0, 1'b1, 2'd2, 0, 0, 7'd0,  16'h0000};
        vecs[2] = '{2'd0, 1'b0, 1'b0, 2'd0, 1, 8, 7'd0,  16'hA5A5};
        vecs[3] = '{2'd1, 1'b1, 1'b0, 2'd1, 1, 8, 7'd8,  16'hF3F5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mmcm_rst", 32'(o_mmcm_rst), 32'd1);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd1);
        chk("rst_cur_mode", 32'(o_cur_mode), 32'd0);
        chk("rst_lock_lost", 32'(o_lock_lost), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_den_dwe_done", 32'({o_den, o_dwe, o_done}), 32'd0);

        // Boot: hold, release, lock, idle without o_done or DRP traffic
        i_rst = 1'b0;
        wait_ready(1000, "boot_ready");
        repeat (2) @(negedge clk);
        chk("boot_cur_mode", 32'(o_cur_mode), 32'd0);
        chk("boot_done", 32'(done_total), 32'd0);
        chk("boot_den", 32'(den_total), 32'd0);
        chk("boot_mmcm_rst", 32'(o_mmcm_rst), 32'd0);

        // Table-driven mode switches
        for (int i = 0; i < 4; i++) begin
            do_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Lock never rises: initial pulse plus MAX_RETRY retries, then error
        lock_en = 1'b0;
        r0 = rst_rises;
        d0 = done_total;
        req(2'd2);
        wait_ready(4000, "nolock_ready");
        repeat (2) @(negedge clk);
        chk("nolock_rst_pulses", 32'(rst_rises - r0), 32'd4);
        chk("nolock_err", 32'(o_err), 32'd1);
        chk("nolock_cur_mode", 32'(o_cur_mode), 32'd1);
        chk("nolock_done", 32'(done_total - d0), 32'd0);
        chk("nolock_mmcm_rst", 32'(o_mmcm_rst), 32'd0);
        lock_en = 1'b1;

        // Reset during RD_WAIT abandons the access and restarts the boot
        req(2'd2);
        k = 0;
        while (!o_den && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_den_seen", 32'(o_den), 32'd1);
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        chk("midrst_den", 32'(o_den), 32'd0);
        chk("midrst_mmcm_rst", 32'(o_mmcm_rst), 32'd1);
        chk("midrst_ready", 32'(o_ready), 32'd0);
        chk("midrst_cur_mode", 32'(o_cur_mode), 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        d0 = den_total;
        wait_ready(1000, "reboot_ready");
        chk("reboot_den", 32'(den_total - d0), 32'd0);
        do_vec(vecs[3], "after_rst");

        // Lock drop while idle is counted, no automatic recovery
        chk("pre_drop_lost", 32'(o_lock_lost), 32'd0);
        drop_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("drop_lock_lost", 32'(o_lock_lost), 32'd1);
        chk("drop_ready", 32'(o_ready), 32'd1);
        chk("drop_mmcm_rst", 32'(o_mmcm_rst), 32'd0);

        // DRP protocol rules over the whole run
        chk("no_back_to_back_den", 32'(b2b_viol), 32'd0);
        chk("rst_high_during_writes", 32'(rst_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
